// File: rtl/jtframe_sdram_sched_pkg.sv
// Shared definitions for the SDRAM port scheduler: FSM state encoding and
// starvation counter width, also visible to the bench.
package jtframe_sdram_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT    = 2'd2,
      ST_REFRESH = 2'd3
   } state_t;

   localparam int WCW = 4;

endpackage

// File: rtl/jtframe_sdram_sched_pick.sv
// Combinational N-way picker: lowest-index urgent eligible port wins,
// otherwise the lowest-index eligible port.
module jtframe_sched_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] eligible,
   input  logic [N-1:0] urgent,
   output logic [N-1:0] sel,
   output logic         any
);

   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] urg_el;

   // x & -x isolates the lowest set bit
   assign urg_el = urgent & eligible;
   assign sel    = (|urg_el) ? (urg_el & (~urg_el + ONE))
                             : (eligible & (~eligible + ONE));
   assign any    = |eligible;

endmodule

// File: rtl/jtframe_sdram_sched.sv
// Shares one SDRAM controller port among N requesters: fixed priority with
// anti-starvation promotion, plus forced/opportunistic refresh scheduling.
module jtframe_sdram_sched
   import jtframe_sdram_sched_pkg::*;
#(
   parameter int N        = 4,
   parameter int AW       = 22,
   parameter int WAIT_MAX = 4,
   parameter int REF_MAX  = 512,
   parameter int REF_CYC  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vblank,
   input  logic              downloading,
   input  logic [N-1:0]      req,
   input  logic [N-1:0]      we,
   input  logic [N*AW-1:0]   addr,
   input  logic [N*32-1:0]   din,
   input  logic [N*4-1:0]    wmask,
   output logic [N-1:0]      ok,
   output logic [31:0]       dout,
   output logic              sdram_req,
   input  logic              sdram_ack,
   output logic              sdram_we,
   output logic [AW-1:0]     sdram_addr,
   output logic [31:0]       sdram_din,
   output logic [3:0]        sdram_wmask,
   input  logic              data_rdy,
   input  logic [31:0]       data_read,
   output logic              refresh_en
);

   localparam int RW = $clog2(REF_MAX + 1);
   localparam int TW = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;
   localparam logic [RW-1:0]  REF_TOP  = RW'(REF_MAX);
   localparam logic [TW-1:0]  TMR_LAST = TW'(REF_CYC - 1);
   localparam logic [WCW-1:0] WAIT_TOP = WCW'(WAIT_MAX);

   state_t                  state, nxt;
   logic [N-1:0]            eligible, urgent, sel, sel_q;
   logic                    any, do_grant, do_ref, do_done;
   logic [N-1:0][WCW-1:0]   wait_cnt;
   logic [RW-1:0]           ref_cnt;
   logic [TW-1:0]           ref_tmr;
   logic                    g_we;
   logic [AW-1:0]           g_addr;
   logic [31:0]             g_din;
   logic [3:0]              g_wmask;

   // A port whose ok is pulsing still has req high; it must not be re-served
   assign eligible = req & ~ok;

   always_comb begin
      urgent = '0;
      for (int i = 0; i < N; i++) urgent[i] = (wait_cnt[i] == WAIT_TOP);
   end

   jtframe_sched_pick #(.N(N)) u_pick (
      .eligible (eligible),
      .urgent   (urgent),
      .sel      (sel),
      .any      (any)
   );

   always_comb begin
      g_we    = 1'b0;
      g_addr  = '0;
      g_din   = '0;
      g_wmask = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) begin
            g_we    = we[i];
            g_addr  = addr[i*AW +: AW];
            g_din   = din[i*32 +: 32];
            g_wmask = wmask[i*4 +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (ref_cnt == REF_TOP)        nxt = ST_REFRESH;
            else if (any && !downloading)  nxt = ST_REQ;
            else if (vblank && !any)       nxt = ST_REFRESH;
         end
         ST_REQ:     if (sdram_ack) nxt = data_rdy ? ST_IDLE : ST_WAIT;
         ST_WAIT:    if (data_rdy) nxt = ST_IDLE;
         ST_REFRESH: if (ref_tmr == TMR_LAST) nxt = ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      do_grant = (state == ST_IDLE) && (nxt == ST_REQ);
      do_ref   = (state == ST_IDLE) && (nxt == ST_REFRESH);
      do_done  = ((state == ST_REQ) && sdram_ack && data_rdy) ||
                 ((state == ST_WAIT) && data_rdy);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdram_req   <= 1'b0;
         sdram_we    <= 1'b0;
         sdram_addr  <= '0;
         sdram_din   <= '0;
         sdram_wmask <= '0;
         sel_q       <= '0;
         ok          <= '0;
         dout        <= '0;
         refresh_en  <= 1'b0;
         ref_cnt     <= '0;
         ref_tmr     <= '0;
      end else begin
         if (do_grant) begin
            sdram_req   <= 1'b1;
            sdram_we    <= g_we;
            sdram_addr  <= g_addr;
            sdram_din   <= g_din;
            sdram_wmask <= g_wmask;
            sel_q       <= sel;
         end else if (state == ST_REQ && sdram_ack) begin
            sdram_req <= 1'b0;
         end
         ok <= do_done ? sel_q : '0;
         if (do_done && !sdram_we) dout <= data_read;
         refresh_en <= do_ref;
         if (do_ref)                  ref_cnt <= '0;
         else if (ref_cnt != REF_TOP) ref_cnt <= ref_cnt + RW'(1);
         if (do_ref)                  ref_tmr <= '0;
         else if (state == ST_REFRESH) ref_tmr <= ref_tmr + TW'(1);
      end
   end

   // Starvation counters are frozen entirely while downloading
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!downloading) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] || (do_grant && sel[i]))
               wait_cnt[i] <= '0;
            else if (do_grant && wait_cnt[i] != WAIT_TOP)
               wait_cnt[i] <= wait_cnt[i] + WCW'(1);
         end
      end
   end

endmodule
